// File: rtl/acc_reg_pkg.sv
// Shared types and default sizes for the accumulator register bank.
// Holds the register-op encoding, the shadow sequencer state encoding and
// the default DW/AW/NTAP values used by acc_reg_bank and its sub-module.
package acc_reg_pkg;

  localparam int unsigned ACC_DW_DEF   = 8;
  localparam int unsigned ACC_AW_DEF   = 4;
  localparam int unsigned ACC_NTAP_DEF = 2;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_ST   = 2'd1,
    OP_LD   = 2'd2,
    OP_SWAP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_SAVE    = 2'd1,
    SEQ_RESTORE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/acc_reg_shadow_seq.sv
// Shadow bank plus save/restore sequencer. Copies one entry per cycle
// between the core bank (owned by the parent) and the local shadow bank.
// Ports:
//   clk, reset            - clock, async active-high reset
//   save_req, restore_req - level requests, sampled only while idle
//   core_dat              - core[idx] read back from the parent
//   busy                  - high while a SAVE or RESTORE is running
//   done                  - one-cycle pulse after the last entry is copied
//   idx                   - entry being copied this cycle
//   restore_we/_dat       - core[idx] write request during RESTORE
module acc_reg_shadow_seq
  import acc_reg_pkg::*;
#(
  parameter int unsigned DW = ACC_DW_DEF,
  parameter int unsigned AW = ACC_AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          save_req,
  input  logic          restore_req,
  input  logic [DW-1:0] core_dat,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] idx,
  output logic          restore_we,
  output logic [DW-1:0] restore_dat
);

  localparam int unsigned DEPTH = 1 << AW;

  seq_state_e    state_q, state_d;
  logic [AW-1:0] idx_q;
  logic          done_q;
  logic          last_c;
  logic [DW-1:0] shadow_q [DEPTH];

  assign last_c = (idx_q == AW'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SEQ_IDLE;
    else       state_q <= state_d;
  end

  // Next state: save wins over restore when both are requested.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: begin
        if (save_req)         state_d = SEQ_SAVE;
        else if (restore_req) state_d = SEQ_RESTORE;
      end
      SEQ_SAVE, SEQ_RESTORE: begin
        if (last_c) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy        = 1'b0;
    restore_we  = 1'b0;
    busy        = (state_q == SEQ_SAVE) || (state_q == SEQ_RESTORE);
    restore_we  = (state_q == SEQ_RESTORE);
  end

  // Index counter and completion pulse; idx wraps back to 0 on the last entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      done_q <= 1'b0;
    end else if (busy) begin
      idx_q  <= idx_q + AW'(1);
      done_q <= last_c;
    end else begin
      idx_q  <= '0;
      done_q <= 1'b0;
    end
  end

  // Shadow storage, written only while saving.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
    end else if (state_q == SEQ_SAVE) begin
      shadow_q[idx_q] <= core_dat;
    end
  end

  assign idx         = idx_q;
  assign done        = done_q;
  assign restore_dat = shadow_q[idx_q];

endmodule

// File: rtl/acc_reg_bank.sv
// Accumulator with a register bank: ST/LD/SWAP between the accumulator and
// core[addr], combinational read port and top-of-bank taps. Optional shadow
// bank with save/restore sequencer when ACC_REG_BANK_SHADOW_EN is defined;
// otherwise save_req/restore_req are ignored and busy/done read 0.
// Ports:
//   clk, reset            - clock, async active-high reset
//   acc_in, acc_ld        - accumulator load data / load enable
//   addr, op              - register select, op (NOP/ST/LD/SWAP)
//   save_req, restore_req - shadow sequencer requests
//   acc_out               - accumulator
//   rd_dat                - core[addr], combinational
//   tap                   - tap[i] = core[DEPTH-NTAP+i], packed i*DW upward
//   busy, done            - sequencer active / completion pulse
module acc_reg_bank
  import acc_reg_pkg::*;
#(
  parameter int unsigned DW   = ACC_DW_DEF,
  parameter int unsigned AW   = ACC_AW_DEF,
  parameter int unsigned NTAP = ACC_NTAP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DW-1:0]      acc_in,
  input  logic               acc_ld,
  input  logic [AW-1:0]      addr,
  input  logic [1:0]         op,
  input  logic               save_req,
  input  logic               restore_req,
  output logic [DW-1:0]      acc_out,
  output logic [DW-1:0]      rd_dat,
  output logic [NTAP*DW-1:0] tap,
  output logic               busy,
  output logic               done
);

  localparam int unsigned DEPTH = 1 << AW;

  op_e           op_c;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] core_q [DEPTH];
  logic          seq_busy, seq_done, seq_we;
  logic [AW-1:0] seq_idx;
  logic [DW-1:0] seq_dat;

  assign op_c = op_e'(op);

`ifdef ACC_REG_BANK_SHADOW_EN
  acc_reg_shadow_seq #(
    .DW(DW),
    .AW(AW)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .save_req   (save_req),
    .restore_req(restore_req),
    .core_dat   (core_q[seq_idx]),
    .busy       (seq_busy),
    .done       (seq_done),
    .idx        (seq_idx),
    .restore_we (seq_we),
    .restore_dat(seq_dat)
  );
`else
  logic unused_req;
  assign unused_req = save_req ^ restore_req;
  assign seq_busy   = 1'b0;
  assign seq_done   = 1'b0;
  assign seq_we     = 1'b0;
  assign seq_idx    = '0;
  assign seq_dat    = '0;
`endif

  // Accumulator: LD/SWAP take priority over acc_ld; frozen while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (!seq_busy) begin
      if (op_c == OP_LD || op_c == OP_SWAP) acc_q <= core_q[addr];
      else if (acc_ld)                      acc_q <= acc_in;
    end
  end

  // Core bank: sequencer restore owns the write port while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) core_q[i] <= '0;
    end else if (seq_we) begin
      core_q[seq_idx] <= seq_dat;
    end else if (!seq_busy && (op_c == OP_ST || op_c == OP_SWAP)) begin
      core_q[addr] <= acc_q;
    end
  end

  for (genvar g = 0; g < NTAP; g++) begin : g_tap
    assign tap[g*DW +: DW] = core_q[DEPTH - NTAP + g];
  end

  assign acc_out = acc_q;
  assign rd_dat  = core_q[addr];
  assign busy    = seq_busy;
  assign done    = seq_done;

endmodule

// File: tb/tb_acc_reg_bank.sv
// Scoreboard bench for acc_reg_bank (default parameters). A driver steps a
// behavioural model each clock and queues the expected outputs; a monitor on
// the falling edge pops and compares against the DUT.
module tb_acc_reg_bank;

  localparam int DEPTH = 16;
`ifdef ACC_REG_BANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, acc_ld, save_req, restore_req;
  logic [7:0]  acc_in;
  logic [3:0]  addr;
  logic [1:0]  op;
  logic [7:0]  acc_out, rd_dat;
  logic [15:0] tap;
  logic        busy, done;

  always #5 clk = ~clk;

  acc_reg_bank dut (
    .clk(clk), .reset(reset), .acc_in(acc_in), .acc_ld(acc_ld), .addr(addr),
    .op(op), .save_req(save_req), .restore_req(restore_req),
    .acc_out(acc_out), .rd_dat(rd_dat), .tap(tap), .busy(busy), .done(done)
  );

  // Behavioural model: mode 0 idle, 1 saving, 2 restoring; pos = next entry.
  logic [7:0] m_acc;
  logic [7:0] m_core [DEPTH];
  logic [7:0] m_sh   [DEPTH];
  int         m_mode, m_pos;
  logic       m_done;

  typedef struct {
    logic [7:0]  acc;
    logic [7:0]  rd;
    logic [15:0] tap;
    logic        busy;
    logic        done;
    string       tag;
  } exp_t;

  exp_t  q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  string phase = "reset";

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    m_acc = '0; m_mode = 0; m_pos = 0; m_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_core[i] = '0; m_sh[i] = '0; end
  endfunction

  // One rising edge with the inputs currently applied.
  function automatic void model_step();
    logic [7:0] old_acc, old_reg;
    if (reset) begin model_clear(); return; end
    if (m_mode != 0) begin
      if (m_mode == 1) m_sh[m_pos] = m_core[m_pos];
      else             m_core[m_pos] = m_sh[m_pos];
      m_done = (m_pos == DEPTH - 1);
      if (m_done) m_mode = 0;
      else        m_pos++;
    end else begin
      m_done  = 1'b0;
      old_acc = m_acc;
      old_reg = m_core[addr];
      if (op == 2'd1 || op == 2'd3) m_core[addr] = old_acc;
      if (op == 2'd2 || op == 2'd3) m_acc = old_reg;
      else if (acc_ld)              m_acc = acc_in;
      if (SHADOW) begin
        if (save_req)         begin m_mode = 1; m_pos = 0; end
        else if (restore_req) begin m_mode = 2; m_pos = 0; end
      end
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.acc  = m_acc;
    e.rd   = m_core[addr];
    e.tap  = {m_core[DEPTH-1], m_core[DEPTH-2]};
    e.busy = (m_mode != 0);
    e.done = m_done;
    e.tag  = phase;
    q.push_back(e);
  endfunction

  // Clock edge, then apply the inputs for the next edge and queue expectations.
  task automatic cyc(input logic r, input logic ld, input logic [7:0] d,
                     input logic [3:0] a, input logic [1:0] o,
                     input logic sv, input logic rs);
    @(posedge clk);
    model_step();
    #1;
    reset = r; acc_ld = ld; acc_in = d; addr = a; op = o;
    save_req = sv; restore_req = rs;
    if (r) model_clear();
    push_exp();
  endtask

  task automatic nop(input logic [3:0] a);
    cyc(1'b0, 1'b0, 8'h00, a, 2'd0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".acc_out"}, 16'(acc_out), 16'(e.acc));
      chk({e.tag, ".rd_dat"},  16'(rd_dat),  16'(e.rd));
      chk({e.tag, ".tap"},     tap,          e.tap);
      chk({e.tag, ".busy"},    16'(busy),    16'(e.busy));
      chk({e.tag, ".done"},    16'(done),    16'(e.done));
    end
  end

  initial begin
    model_clear();
    reset = 1'b1; acc_ld = 1'b0; acc_in = '0; addr = '0; op = '0;
    save_req = 1'b0; restore_req = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    nop(4'd0);

    phase = "ld_st";
    cyc(1'b0, 1'b1, 8'h5A, 4'd3, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 4'd3, 2'd1, 1'b0, 1'b0);
    nop(4'd3);

    phase = "swap";
    cyc(1'b0, 1'b1, 8'h22, 4'd2, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 4'd2, 2'd1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h11, 4'd2, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 4'd2, 2'd3, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h77, 4'd2, 2'd2, 1'b0, 1'b0);
    nop(4'd2);

    phase = "taps";
    cyc(1'b0, 1'b1, 8'hEE, 4'd14, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hFF, 4'd14, 2'd1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 4'd15, 2'd1, 1'b0, 1'b0);
    nop(4'd14);

    phase = "fill";
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, 8'(i + 1), 4'(i), 2'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 4'(i), 2'd1, 1'b0, 1'b0);
    end
    phase = "save";
    cyc(1'b0, 1'b1, 8'h00, 4'd0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 1'b1, 8'h99, 4'(i), 2'd1, 1'b0, 1'b1);
    phase = "zero";
    cyc(1'b0, 1'b1, 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 8'h00, 4'(i), 2'd1, 1'b0, 1'b0);
    phase = "restore";
    cyc(1'b0, 1'b0, 8'h00, 4'd5, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b1, 8'hA5, 4'(i), 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) nop(4'(i));

    phase = "both_reset";
    cyc(1'b0, 1'b0, 8'h00, 4'd1, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) nop(4'(i));
    cyc(1'b1, 1'b0, 8'h00, 4'd7, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 4'd7, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) nop(4'(DEPTH - 1 - i));

    phase = "rand";
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 1)),
          8'($urandom),
          4'($urandom),
          2'($urandom),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 24) == 0));
    end
    nop(4'd0);

    repeat (2) @(negedge clk);
    chk("drain.queue_left", 16'(q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
